// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage types and constants for the MIPS front end.
// Holds the queue entry layout and the PC alignment helper.
package mips_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Word-align a fetch target; the two low bits carry no meaning.
  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {inst, pc} entries with a flush input.
// The head is read straight out of the storage flops, so it changes only on a clock edge.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       flush,
  input  logic                       push,
  input  logic [XLEN-1:0]            pushInst,
  input  logic [XLEN-1:0]            pushPc,
  input  logic                       pop,
  output logic                       headValid,
  output logic [XLEN-1:0]            headInst,
  output logic [XLEN-1:0]            headPc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic          doPush;
  logic          doPop;

  assign doPop  = pop && (count != '0);
  assign doPush = push && !flush && ((count < CW'(DEPTH)) || doPop);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{inst: INST_NOP, pc: '0};
      end
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= '{inst: pushInst, pc: pushPc};
      end
      // A flush drops every entry, including one being popped this cycle.
      if (flush) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else begin
        if (doPop) rdPtr <= rdPtr + AW'(1);
        if (doPush) wrPtr <= wrPtr + AW'(1);
        count <= count + CW'(doPush) - CW'(doPop);
      end
    end
  end

  assign headValid = (count != '0);
  assign headInst  = mem[rdPtr].inst;
  assign headPc    = mem[rdPtr].pc;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues credit-limited memory requests and
// feeds decode from a prefetch queue; redirects squash everything in flight.
module instruction_fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] rspPc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstandingNext;
  logic [CW-1:0]   stale;
  logic [CW-1:0]   queueCount;
  logic [CW:0]     credit;
  logic            reqFire;
  logic            rspLive;
  logic            rspStale;

  // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
  assign credit         = {1'b0, queueCount} + {1'b0, outstanding};
  assign imem_req_valid = Reset && (credit < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetchPc;
  assign reqFire        = imem_req_valid && imem_req_ready;

  assign rspStale = imem_rsp_valid && (stale != '0);
  assign rspLive  = imem_rsp_valid && (stale == '0);

  assign outstandingNext = outstanding + CW'(reqFire) - CW'(imem_rsp_valid);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetchPc     <= RESET_PC;
      rspPc       <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      outstanding <= outstandingNext;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        fetchPc <= alignPc(redirect_pc);
        rspPc   <= alignPc(redirect_pc);
        stale   <= outstandingNext;
      end else begin
        if (reqFire) fetchPc <= fetchPc + PC_STEP;
        if (rspLive) rspPc <= rspPc + PC_STEP;
        if (rspStale) stale <= stale - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rstN     (Reset),
    .flush    (redirect_valid),
    .push     (rspLive),
    .pushInst (imem_rsp_data),
    .pushPc   (rspPc),
    .pop      (inst_ready),
    .headValid(inst_valid),
    .headInst (inst),
    .headPc   (inst_pc),
    .count    (queueCount)
  );

  assign inst_pc4 = inst_pc + PC_STEP;

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

- Fetch stage directly upstream of the single-cycle controller/datapath.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses.
- Buffers returned instructions in a small prefetch queue and presents them to decode with a valid/ready handshake, along with each instruction's PC and PC+4 (the link value).
- Accepts a redirect from branch/jump resolution: it flushes buffered and in-flight instructions and restarts fetch at the new target.

## Interface
Parameters:
- DEPTH, 4: prefetch queue entries and the cap on queued plus in-flight instructions; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word address, bits [1:0] always 0.
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  taken branch, J, JAL or JR resolved this cycle.
- redirect_pc  in  32  target; bits [1:0] ignored and forced to 0.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode consumes the head.
- inst  out  32  head instruction (32'h0 is a NOP and is passed through unchanged).
- inst_pc  out  32  PC of head.
- inst_pc4  out  32  inst_pc + 4, modulo 2^32.

## Operation
- State: fetch_pc (32b), queue (DEPTH × {inst, pc}), outstanding count, stale count. Both counters are $clog2(DEPTH+1) bits.
- Issue rule: imem_req_valid = (count + outstanding < DEPTH) and not in reset. imem_req_addr = fetch_pc.
- On a request handshake: fetch_pc += 4 (wraps 32'hFFFF_FFFC → 0) and outstanding increments.
- Response with stale > 0: discarded; stale and outstanding both decrement.
- Response with stale = 0: enqueued with its PC (the queue tracks the PC of the oldest live in-flight request); outstanding decrements.
- Dequeue happens on inst_valid & inst_ready.
- Redirect (highest priority) takes effect in the same edge:
  - fetch_pc ← {redirect_pc[31:2], 2'b00}; queue emptied.
  - stale ← all in-flight requests, including any request handshaken and any response arriving in the redirect cycle (a response in that cycle is discarded).
  - A dequeue in the redirect cycle is still a valid consume.
- The credit rule prevents overflow. Enqueue and dequeue in the same cycle leaves count unchanged.
- Reset mid-operation: all state cleared immediately. Responses that arrive after reset release belong to the old stream and must not occur; memory is reset together with this block.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, inst_valid 0, inst 0, inst_pc 0, inst_pc4 4, all counters 0.
- First request is asserted in the first cycle after Reset deasserts.
- Latency: a response accepted at edge N gives inst_valid at N+1 (registered queue output).
- With one-cycle memory and inst_ready held high, sustained throughput is one instruction per cycle.
- Redirect at edge N: inst_valid = 0 after N. The first request to the target is issued in the cycle after N, and the target instruction appears one cycle after its response.
- Outputs are stable while inst_valid & ~inst_ready. imem_req_addr is stable while imem_req_valid & ~imem_req_ready, unless a redirect occurs.

## Structure
- Shared package mips_fetch_pkg:
  - XLEN = 32, PC_STEP = 4, INST_NOP = 32'h0.
  - typedef fetch_entry_t {logic [31:0] inst; logic [31:0] pc;}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with a flush input, count output, and registered head.
- Credit/stale logic and the PC register live in instruction_fetch_queue.

## Test plan
- Reset release, 1-cycle memory, inst_ready = 1 → request addresses 0x0, 0x4, 0x8…; inst_pc follows the same sequence with inst_pc4 = inst_pc + 4; one instruction per cycle after the 2-cycle fill.
- inst_ready = 0 with DEPTH = 4 → exactly 4 requests issued, then imem_req_valid stays 0. Raising inst_ready drains entries 0x0–0xC in order, then fetch resumes at 0x10.
- 3-cycle memory with 2 requests outstanding, redirect_pc = 0x1003 → both old responses dropped, next address 0x1000, first delivered inst_pc 0x1000.
- Redirect in the same cycle as a response and a request handshake → neither the response nor the instruction for that request is ever delivered; stream restarts cleanly.
- fetch_pc at 0xFFFF_FFFC → next request address 0x0; inst_pc4 for that entry is 0x0.
- Reset asserted mid-stream with a full queue → inst_valid and imem_req_valid drop asynchronously; after release, fetch restarts at RESET_PC.
